hbconsole_arb: RTL and testbench

Parametrised output arbiter and console splitter for the hexbus debug link. It merges the hexbus response byte stream with a buffered console byte stream onto one serial transmit channel, tagging each byte with bit 7. Hexbus bytes carry bit 7 set; console bytes carry bit 7 clear. It also extracts console bytes (bit 7 clear) from the received stream. The block sits between the hexbus newline stage and the UART transmitter, and replaces the single-register arbitration at the end of the console pipeline with a FIFO-backed, fairness-limited one.

---
 rtl/hbconsole_arb.sv | 149 ++++++++++++++
 tb/tb_hbconsole_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hbconsole_arb.sv
// Hexbus/console transmit arbiter with a console FIFO and a receive-side console splitter.
// Define HBCONSOLE_FAIRNESS_EN to cap hexbus bursts at MAXBURST while console data waits.
module hbconsole_arb #(
    parameter int LGFIFO   = 4,
    parameter int MAXBURST = 16
) (
    input  logic       i_clk,
    input  logic       w_reset,
    input  logic       i_rx_stb,
    input  logic [7:0] i_rx_byte,
    output logic       o_console_stb,
    output logic [6:0] o_console_data,
    input  logic       i_hb_stb,
    input  logic [7:0] i_hb_byte,
    output logic       o_hb_busy,
    input  logic       i_console_stb,
    input  logic [6:0] i_console_data,
    output logic       o_console_busy,
    output logic       o_tx_stb,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_busy,
    output logic       o_overflow
);
    localparam int DEPTH = 1 << LGFIFO;
    localparam logic [LGFIFO:0]   FULL_LVL = (LGFIFO+1)'(DEPTH);
    localparam logic [LGFIFO:0]   FILL_ONE = (LGFIFO+1)'(1);
    localparam logic [LGFIFO-1:0] PTR_ONE  = LGFIFO'(1);

    logic [6:0]        mem_q [DEPTH];
    logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFIFO-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFIFO:0]   fill_q, fill_d;
    logic              ps_full_q, ps_full_d;
    logic [7:0]        ps_data_q, ps_data_d;
    logic              overflow_q, overflow_d;
    logic              con_stb_q, con_stb_d;
    logic [6:0]        con_data_q, con_data_d;

    logic       fifo_empty, fifo_full, fifo_wr, fifo_rd;
    logic       load_ok, sel_hb, sel_con;
    logic [6:0] fifo_head;
    logic       unused_hb_bit7;

    assign unused_hb_bit7 = i_hb_byte[7];

`ifdef HBCONSOLE_FAIRNESS_EN
    localparam logic [7:0] MAXB = 8'(MAXBURST);
    logic [7:0] burst_q, burst_d;
`endif

    always_comb begin
        fifo_empty = (fill_q == '0);
        fifo_full  = (fill_q == FULL_LVL);
        fifo_head  = mem_q[rd_ptr_q];
        load_ok    = !ps_full_q || !i_tx_busy;
`ifdef HBCONSOLE_FAIRNESS_EN
        sel_hb     = i_hb_stb && (fifo_empty || (burst_q < MAXB));
`else
        sel_hb     = i_hb_stb;
`endif
        sel_con    = !sel_hb && !fifo_empty;
        fifo_rd    = load_ok && sel_con;
        fifo_wr    = i_console_stb && !fifo_full;
    end

    always_comb begin
        wr_ptr_d = fifo_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = fifo_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        fill_d   = fill_q;
        if (fifo_wr && !fifo_rd)
            fill_d = fill_q + FILL_ONE;
        else if (!fifo_wr && fifo_rd)
            fill_d = fill_q - FILL_ONE;
    end

    // Loading on a handoff cycle keeps the channel at one byte per clock.
    always_comb begin
        ps_full_d = ps_full_q;
        ps_data_d = ps_data_q;
        if (load_ok) begin
            if (sel_hb) begin
                ps_full_d = 1'b1;
                ps_data_d = {1'b1, i_hb_byte[6:0]};
            end else if (sel_con) begin
                ps_full_d = 1'b1;
                ps_data_d = {1'b0, fifo_head};
            end else begin
                ps_full_d = 1'b0;
            end
        end
    end

`ifdef HBCONSOLE_FAIRNESS_EN
    always_comb begin
        burst_d = burst_q;
        if (fifo_rd || fifo_empty)
            burst_d = 8'd0;
        else if (load_ok && sel_hb && (burst_q < MAXB))
            burst_d = burst_q + 8'd1;
    end
`endif

    always_comb begin
        overflow_d = overflow_q || (i_console_stb && fifo_full);
        con_stb_d  = i_rx_stb && !i_rx_byte[7];
        con_data_d = i_rx_byte[6:0];
    end

    always_ff @(posedge i_clk) begin
        if (fifo_wr)
            mem_q[wr_ptr_q] <= i_console_data;
    end

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            ps_full_q  <= 1'b0;
            ps_data_q  <= 8'd0;
            overflow_q <= 1'b0;
            con_stb_q  <= 1'b0;
            con_data_q <= 7'd0;
`ifdef HBCONSOLE_FAIRNESS_EN
            burst_q    <= 8'd0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            ps_full_q  <= ps_full_d;
            ps_data_q  <= ps_data_d;
            overflow_q <= overflow_d;
            con_stb_q  <= con_stb_d;
            con_data_q <= con_data_d;
`ifdef HBCONSOLE_FAIRNESS_EN
            burst_q    <= burst_d;
`endif
        end
    end

    assign o_console_stb  = con_stb_q;
    assign o_console_data = con_data_q;
    assign o_hb_busy      = !(load_ok && sel_hb);
    assign o_console_busy = fifo_full;
    assign o_tx_stb       = ps_full_q;
    assign o_tx_data      = ps_data_q;
    assign o_overflow     = overflow_q;
endmodule

// File: tb/tb_hbconsole_arb.sv
// Self-checking bench for hbconsole_arb: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_hbconsole_arb;
  localparam int LGFIFO   = 4;
  localparam int MAXBURST = 16;
  localparam int DEPTH    = 1 << LGFIFO;

  logic       i_clk = 1'b0;
  logic       w_reset = 1'b1;
  logic       i_rx_stb = 1'b0;
  logic [7:0] i_rx_byte = 8'd0;
  logic       o_console_stb;
  logic [6:0] o_console_data;
  logic       i_hb_stb = 1'b0;
  logic [7:0] i_hb_byte = 8'd0;
  logic       o_hb_busy;
  logic       i_console_stb = 1'b0;
  logic [6:0] i_console_data = 7'd0;
  logic       o_console_busy;
  logic       o_tx_stb;
  logic [7:0] o_tx_data;
  logic       i_tx_busy = 1'b0;
  logic       o_overflow;

  hbconsole_arb #(.LGFIFO(LGFIFO), .MAXBURST(MAXBURST)) dut (
    .i_clk(i_clk), .w_reset(w_reset),
    .i_rx_stb(i_rx_stb), .i_rx_byte(i_rx_byte),
    .o_console_stb(o_console_stb), .o_console_data(o_console_data),
    .i_hb_stb(i_hb_stb), .i_hb_byte(i_hb_byte), .o_hb_busy(o_hb_busy),
    .i_console_stb(i_console_stb), .i_console_data(i_console_data),
    .o_console_busy(o_console_busy),
    .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
    .o_overflow(o_overflow)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  bit         m_full;
  logic [7:0] m_data;
  logic [6:0] m_fifo[$];
  int         m_burst;
  bit         m_ovf;
  bit         m_cstb;
  logic [6:0] m_cdata;
  bit         chk_en = 1'b0;
  int         cstb_count;

  // scoreboard: accepted bytes per source, and the log of bytes handed to the UART
  logic [6:0] hb_exp_q[$];
  logic [6:0] con_exp_q[$];
  logic [7:0] tx_log[$];

  task automatic model_reset();
    m_full = 1'b0; m_data = 8'd0; m_fifo.delete(); m_burst = 0; m_ovf = 1'b0;
    m_cstb = 1'b0; m_cdata = 7'd0;
    hb_exp_q.delete(); con_exp_q.delete();
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic step();
    bit empty, full, load_ok, sel_hb;
    logic [6:0] v;
    #1;
    empty   = (m_fifo.size() == 0);
    full    = (m_fifo.size() == DEPTH);
    load_ok = !m_full || !i_tx_busy;
`ifdef HBCONSOLE_FAIRNESS_EN
    sel_hb  = i_hb_stb && (empty || m_burst < MAXBURST);
`else
    sel_hb  = i_hb_stb;
`endif
    if (chk_en) begin
      check("tx_stb", o_tx_stb, m_full);
      check("tx_data", o_tx_data, m_data);
      check("hb_busy", o_hb_busy, !(load_ok && sel_hb));
      check("console_busy", o_console_busy, full);
      check("overflow", o_overflow, m_ovf);
      check("console_stb", o_console_stb, m_cstb);
      check("console_data", o_console_data, m_cdata);
      if (o_console_stb) cstb_count++;
      if (o_tx_stb && !i_tx_busy && !w_reset) begin
        tx_log.push_back(o_tx_data);
        if (o_tx_data[7]) begin
          check("sb_hb_avail", hb_exp_q.size() > 0, 1);
          if (hb_exp_q.size() > 0) begin
            v = hb_exp_q.pop_front();
            check("sb_hb_order", o_tx_data[6:0], v);
          end
        end else begin
          check("sb_con_avail", con_exp_q.size() > 0, 1);
          if (con_exp_q.size() > 0) begin
            v = con_exp_q.pop_front();
            check("sb_con_order", o_tx_data[6:0], v);
          end
        end
      end
    end
    if (w_reset) begin
      model_reset();
    end else begin
      if (load_ok && !sel_hb && !empty) m_burst = 0;
      else if (empty) m_burst = 0;
      else if (load_ok && sel_hb && m_burst < MAXBURST) m_burst = m_burst + 1;
      if (load_ok) begin
        if (sel_hb) begin
          m_full = 1'b1;
          m_data = {1'b1, i_hb_byte[6:0]};
          hb_exp_q.push_back(i_hb_byte[6:0]);
        end else if (!empty) begin
          m_full = 1'b1;
          m_data = {1'b0, m_fifo.pop_front()};
        end else begin
          m_full = 1'b0;
        end
      end
      if (i_console_stb && !full) begin
        m_fifo.push_back(i_console_data);
        con_exp_q.push_back(i_console_data);
      end
      if (i_console_stb && full) m_ovf = 1'b1;
      m_cstb  = i_rx_stb && !i_rx_byte[7];
      m_cdata = i_rx_byte[6:0];
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_rx_stb = 1'b0; i_hb_stb = 1'b0; i_console_stb = 1'b0; i_tx_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    w_reset = 1'b1;
    step();
    w_reset = 1'b0;
  endtask

  int con_pos;

  initial begin
    @(negedge i_clk);
    do_reset();
    chk_en = 1'b1;

    // idle after reset
    repeat (3) step();
    check("idle_tx_stb", o_tx_stb, 0);
    check("idle_tx_data", o_tx_data, 0);
    check("idle_console_stb", o_console_stb, 0);
    check("idle_console_data", o_console_data, 0);
    check("idle_overflow", o_overflow, 0);
    check("idle_console_busy", o_console_busy, 0);

    // RX split
    cstb_count = 0;
    i_rx_stb = 1'b1; i_rx_byte = 8'h41; step();
    i_rx_byte = 8'hC1; step();
    i_rx_stb = 1'b0; step(); step();
    check("rx_pulse_count", cstb_count, 1);

    // hexbus stream against one console byte
    do_reset();
    tx_log.delete();
    for (int c = 0; c < 40; c++) begin
      i_hb_stb = 1'b1; i_hb_byte = 8'h35;
      i_console_stb = (c == 0); i_console_data = 7'h61;
      step();
    end
    idle_inputs();
    repeat (5) step();
    con_pos = -1;
    foreach (tx_log[k]) if (tx_log[k] == 8'h61 && con_pos < 0) con_pos = k;
    check("stream_len", tx_log.size(), 41);
    check("stream_first", tx_log[0], 8'hB5);
`ifdef HBCONSOLE_FAIRNESS_EN
    // the hexbus byte taken on the write cycle precedes MAXBURST more
    check("con_pos", con_pos, MAXBURST + 1);
`else
    check("con_pos", con_pos, 40);
`endif

    // FIFO fill, overflow, drain and wrap
    do_reset();
    i_tx_busy = 1'b1; i_hb_stb = 1'b1; i_hb_byte = 8'h12; step();
    i_hb_stb = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      i_console_stb = 1'b1; i_console_data = 7'(k); step();
    end
    i_console_stb = 1'b0;
    check("fill_busy", o_console_busy, 1);
    check("fill_overflow", o_overflow, 1);
    tx_log.delete();
    i_tx_busy = 1'b0;
    repeat (DEPTH + 4) step();
    check("drain_len", tx_log.size(), DEPTH + 1);
    check("drain_first", tx_log[0], 8'h92);
    for (int k = 0; k < DEPTH; k++) check("drain_order", tx_log[k+1], k);
    for (int k = 0; k < 20; k++) begin
      i_console_stb = 1'b1; i_console_data = 7'(7'h40 + k); step();
    end
    i_console_stb = 1'b0;
    repeat (5) step();
    check("overflow_sticky", o_overflow, 1);

    // reset mid-transfer with three bytes queued
    do_reset();
    i_tx_busy = 1'b1; i_hb_stb = 1'b1; i_hb_byte = 8'h07; step();
    i_hb_stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_console_stb = 1'b1; i_console_data = 7'(k + 1); step();
    end
    i_console_stb = 1'b0;
    w_reset = 1'b1; step(); w_reset = 1'b0;
    check("rst_tx_stb", o_tx_stb, 0);
    check("rst_console_busy", o_console_busy, 0);
    tx_log.delete();
    i_tx_busy = 1'b0;
    repeat (5) step();
    check("rst_flushed", tx_log.size(), 0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      i_tx_busy      = ($urandom_range(0, 99) < 40);
      i_hb_stb       = ($urandom_range(0, 99) < 50);
      i_hb_byte      = 8'($urandom);
      i_console_stb  = ($urandom_range(0, 99) < 30);
      i_console_data = 7'($urandom);
      i_rx_stb       = ($urandom_range(0, 99) < 30);
      i_rx_byte      = 8'($urandom);
      step();
    end
    idle_inputs();
    repeat (DEPTH + 10) step();
    check("rand_hb_drained", hb_exp_q.size(), 0);
    check("rand_con_drained", con_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
